// File: rtl/simmem_release_timer.sv
// Per-slot release timer: each accepted entry waits its programmed delay, then its
// slot stays releasable until the response banks release it.
//
// state      | meaning
// FREE       | slot idle, a new entry for this iid may be accepted
// COUNTING   | delay running, counter holds remaining cycles (>= 1)
// RELEASABLE | delay elapsed, release_en bit asserted until the banks release the slot
module simmem_release_timer #(
  parameter int NumSlots   = 8,
  parameter int DelayWidth = 8,
  localparam int IidWidth  = $clog2(NumSlots),
  localparam int CntWidth  = $clog2(NumSlots + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  entry_valid_i,
  output logic                  entry_ready_o,
  input  logic [IidWidth-1:0]   entry_iid_i,
  input  logic [DelayWidth-1:0] entry_delay_i,
  output logic [NumSlots-1:0]   release_en_onehot_o,
  input  logic [NumSlots-1:0]   released_onehot_i,
  output logic [CntWidth-1:0]   busy_cnt_o
);

  typedef enum logic [1:0] {
    FREE       = 2'd0,
    COUNTING   = 2'd1,
    RELEASABLE = 2'd2
  } slot_state_e;

  slot_state_e           state_q [NumSlots];
  logic [DelayWidth-1:0] cnt_q   [NumSlots];
  logic [CntWidth-1:0]   busy_q;
  logic [CntWidth-1:0]   rel_cnt;
  logic                  handshake;

  assign entry_ready_o = (state_q[entry_iid_i] == FREE);
  assign handshake     = entry_valid_i & entry_ready_o;
  assign busy_cnt_o    = busy_q;

  always_comb begin
    release_en_onehot_o = '0;
    for (int i = 0; i < NumSlots; i++) begin
      release_en_onehot_o[i] = (state_q[i] == RELEASABLE);
    end
  end

  // Only releases of slots that are actually releasable count as honoured.
  always_comb begin
    rel_cnt = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (release_en_onehot_o[i] && released_onehot_i[i]) begin
        rel_cnt = rel_cnt + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumSlots; i++) begin
        state_q[i] <= FREE;
        cnt_q[i]   <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        case (state_q[i])
          FREE: begin
            if (handshake && (entry_iid_i == IidWidth'(i))) begin
              if (entry_delay_i == '0) begin
                state_q[i] <= RELEASABLE;
              end else begin
                state_q[i] <= COUNTING;
                cnt_q[i]   <= entry_delay_i;
              end
            end
          end
          COUNTING: begin
            // The last count cycle moves straight to RELEASABLE so the counter never wraps.
            if (cnt_q[i] == DelayWidth'(1)) begin
              state_q[i] <= RELEASABLE;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] != '0) begin
              cnt_q[i] <= cnt_q[i] - DelayWidth'(1);
            end
          end
          RELEASABLE: begin
            if (released_onehot_i[i]) begin
              state_q[i] <= FREE;
            end
          end
          default: begin
            state_q[i] <= FREE;
            cnt_q[i]   <= '0;
          end
        endcase
      end
      busy_q <= busy_q + {{(CntWidth - 1){1'b0}}, handshake} - rel_cnt;
    end
  end

endmodule

// File: tb/tb_simmem_release_timer.sv
// Bench for simmem_release_timer: directed scenarios plus random traffic, checked
// against a time-based model (each busy slot remembers the cycle it becomes releasable).
module tb_simmem_release_timer;
  localparam int N  = 8;
  localparam int DW = 8;
  localparam int IW = 3;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          entry_valid_i = 1'b0;
  logic          entry_ready_o;
  logic [IW-1:0] entry_iid_i = '0;
  logic [DW-1:0] entry_delay_i = '0;
  logic [N-1:0]  release_en_onehot_o;
  logic [N-1:0]  released_onehot_i = '0;
  logic [CW-1:0] busy_cnt_o;

  simmem_release_timer #(.NumSlots(N), .DelayWidth(DW)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .entry_valid_i      (entry_valid_i),
    .entry_ready_o      (entry_ready_o),
    .entry_iid_i        (entry_iid_i),
    .entry_delay_i      (entry_delay_i),
    .release_en_onehot_o(release_en_onehot_o),
    .released_onehot_i  (released_onehot_i),
    .busy_cnt_o         (busy_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit m_busy [N];
  int m_rel  [N];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [N-1:0] exp_en();
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i] = m_busy[i] && (cyc >= m_rel[i]);
    return r;
  endfunction

  function automatic logic [CW-1:0] exp_busy();
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) if (m_busy[i]) c = c + CW'(1);
    return c;
  endfunction

  task automatic idle();
    entry_valid_i     = 1'b0;
    released_onehot_i = '0;
  endtask

  task automatic offer(input int iid, input int d);
    entry_valid_i = 1'b1;
    entry_iid_i   = IW'(iid);
    entry_delay_i = DW'(d);
  endtask

  // Advance one rising edge, updating the model from the inputs held during the cycle.
  task automatic tick();
    int           t;
    logic         hs;
    logic [N-1:0] rel;
    int           iid;
    t   = cyc;
    iid = int'(entry_iid_i);
    hs  = entry_valid_i && !m_busy[iid];
    rel = released_onehot_i & exp_en();
    @(posedge clk_i);
    cyc++;
    for (int i = 0; i < N; i++) if (rel[i]) m_busy[i] = 1'b0;
    if (hs) begin
      m_busy[iid] = 1'b1;
      m_rel[iid]  = t + 1 + int'(entry_delay_i);
    end
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b0;
      m_rel[i]  = 0;
    end
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    idle();
    #1;
    model_clear();
    checks++;
    if (release_en_onehot_o !== '0 || busy_cnt_o !== '0) begin
      errors++;
      $display("FAIL async_reset en=%b busy=%0d required en=0 busy=0", release_en_onehot_o, busy_cnt_o);
    end
    for (int i = 0; i < N; i++) begin
      entry_iid_i = IW'(i);
      #1;
      checks++;
      if (entry_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL ready_in_reset iid=%0d got=%b required=1", i, entry_ready_o);
      end
    end
    @(posedge clk_i);
    cyc++;
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < N; i++) begin
      entry_iid_i = IW'(i);
      #1;
      checks++;
      if (entry_ready_o !== 1'b1 || release_en_onehot_o !== '0 || busy_cnt_o !== '0) begin
        errors++;
        $display("FAIL ready_after_reset iid=%0d ready=%b en=%b busy=%0d required ready=1 en=0 busy=0",
                 i, entry_ready_o, release_en_onehot_o, busy_cnt_o);
      end
    end
  endtask

  task automatic test_reset();
    idle();
    model_clear();
    @(posedge clk_i);
    cyc++;
    #1;
    apply_reset();
  endtask

  task automatic test_d0_release();
    offer(3, 0);
    #1;
    checks++;
    if (entry_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL d0_ready got=%b required=1", entry_ready_o);
    end
    tick();
    idle();
    checks++;
    if (release_en_onehot_o !== 8'b0000_1000 || busy_cnt_o !== 4'd1) begin
      errors++;
      $display("FAIL d0_next_cycle en=%b busy=%0d required en=00001000 busy=1", release_en_onehot_o, busy_cnt_o);
    end
    tick();
    tick();
    checks++;
    if (release_en_onehot_o !== 8'b0000_1000) begin
      errors++;
      $display("FAIL d0_persist en=%b required=00001000", release_en_onehot_o);
    end
    released_onehot_i = 8'b0000_1000;
    tick();
    idle();
    checks++;
    if (release_en_onehot_o !== '0 || busy_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL d0_released en=%b busy=%0d required en=0 busy=0", release_en_onehot_o, busy_cnt_o);
    end
  endtask

  task automatic test_two_slots();
    int t0;
    t0 = cyc;
    offer(2, 5);
    tick();
    offer(5, 1);
    tick();
    idle();
    for (int k = 2; k <= 7; k++) begin
      logic [N-1:0] want;
      want = '0;
      want[5] = (k >= 3);
      want[2] = (k >= 6);
      checks++;
      if (release_en_onehot_o !== want || release_en_onehot_o !== exp_en() || busy_cnt_o !== 4'd2) begin
        errors++;
        $display("FAIL two_slots cycle=+%0d en=%b busy=%0d required en=%b busy=2", k, release_en_onehot_o, busy_cnt_o, want);
      end
      if (k < 7) tick();
    end
    released_onehot_i = 8'b0010_0100;
    tick();
    idle();
    checks++;
    if (busy_cnt_o !== 4'd0 || release_en_onehot_o !== '0) begin
      errors++;
      $display("FAIL two_slots_release en=%b busy=%0d required en=0 busy=0 (t0=%0d)", release_en_onehot_o, busy_cnt_o, t0);
    end
  endtask

  task automatic test_reoffer();
    int waited;
    offer(2, 6);
    tick();
    for (int k = 0; k < 3; k++) begin
      offer(2, 1);
      #1;
      checks++;
      if (entry_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL reoffer_counting_ready got=%b required=0", entry_ready_o);
      end
      tick();
    end
    idle();
    waited = 0;
    while (release_en_onehot_o[2] !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    checks++;
    if (release_en_onehot_o !== exp_en() || release_en_onehot_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL reoffer_release_time en=%b required=%b", release_en_onehot_o, exp_en());
    end
    released_onehot_i = 8'b0000_0100;
    offer(2, 0);
    #1;
    checks++;
    if (entry_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reoffer_no_bypass ready=%b required=0", entry_ready_o);
    end
    tick();
    released_onehot_i = '0;
    offer(2, 0);
    #1;
    checks++;
    if (entry_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reoffer_after_free ready=%b required=1", entry_ready_o);
    end
    tick();
    idle();
    checks++;
    if (release_en_onehot_o !== 8'b0000_0100 || busy_cnt_o !== 4'd1) begin
      errors++;
      $display("FAIL reoffer_reaccept en=%b busy=%0d required en=00000100 busy=1", release_en_onehot_o, busy_cnt_o);
    end
    released_onehot_i = 8'b0000_0100;
    tick();
    idle();
  endtask

  task automatic test_max_delay();
    offer(0, 255);
    tick();
    idle();
    for (int k = 1; k <= 258; k++) begin
      checks++;
      if (release_en_onehot_o[0] !== (k >= 256) || release_en_onehot_o !== exp_en() || busy_cnt_o !== 4'd1) begin
        errors++;
        $display("FAIL max_delay cycle=+%0d en=%b busy=%0d required bit0=%0d busy=1", k, release_en_onehot_o, busy_cnt_o, (k >= 256));
      end
      released_onehot_i = (k == 100) ? 8'b0000_0001 : 8'b0;
      tick();
    end
    released_onehot_i = 8'b0000_0001;
    tick();
    idle();
    checks++;
    if (release_en_onehot_o !== '0 || busy_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL max_delay_release en=%b busy=%0d required en=0 busy=0", release_en_onehot_o, busy_cnt_o);
    end
  endtask

  task automatic test_reset_midcount();
    for (int i = 0; i < N; i++) begin
      offer(i, 20);
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (busy_cnt_o !== 4'd8) begin
      errors++;
      $display("FAIL fill_busy got=%0d required=8", busy_cnt_o);
    end
    apply_reset();
    for (int k = 0; k < 40; k++) begin
      tick();
      checks++;
      if (release_en_onehot_o !== '0 || busy_cnt_o !== '0) begin
        errors++;
        $display("FAIL post_reset_quiet cycle=+%0d en=%b busy=%0d required en=0 busy=0", k, release_en_onehot_o, busy_cnt_o);
      end
    end
  endtask

  task automatic test_same_cycle();
    offer(4, 0);
    tick();
    idle();
    tick();
    offer(1, 3);
    released_onehot_i = 8'b0001_0000;
    tick();
    idle();
    checks++;
    if (busy_cnt_o !== 4'd1 || release_en_onehot_o !== 8'b0) begin
      errors++;
      $display("FAIL same_cycle busy=%0d en=%b required busy=1 en=0", busy_cnt_o, release_en_onehot_o);
    end
    for (int k = 0; k < 3; k++) tick();
    released_onehot_i = 8'b0000_0010;
    tick();
    idle();
    checks++;
    if (busy_cnt_o !== 4'd0 || release_en_onehot_o !== 8'b0) begin
      errors++;
      $display("FAIL same_cycle_drain busy=%0d en=%b required busy=0 en=0", busy_cnt_o, release_en_onehot_o);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      int d;
      d = ($urandom % 8 == 0) ? int'($urandom % 256) : int'($urandom % 6);
      entry_valid_i = 1'($urandom % 2);
      entry_iid_i   = IW'($urandom % N);
      entry_delay_i = DW'(d);
      released_onehot_i = ($urandom % 3 == 0) ? N'($urandom) : '0;
      #1;
      checks++;
      if (entry_ready_o !== !m_busy[int'(entry_iid_i)]) begin
        errors++;
        $display("FAIL random_ready cycle=%0d iid=%0d got=%b required=%b", cyc, entry_iid_i, entry_ready_o, !m_busy[int'(entry_iid_i)]);
      end
      tick();
      checks++;
      if (release_en_onehot_o !== exp_en() || busy_cnt_o !== exp_busy()) begin
        errors++;
        $display("FAIL random_state cycle=%0d en=%b busy=%0d required en=%b busy=%0d",
                 cyc, release_en_onehot_o, busy_cnt_o, exp_en(), exp_busy());
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_d0_release();
    test_two_slots();
    test_reoffer();
    test_max_delay();
    test_reset_midcount();
    test_same_cycle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/simmem_release_timer.md
SIMMEM_RELEASE_TIMER -- requirements
Module: simmem_release_timer

Interface
REQ-001 SHALL have parameter NumSlots, default 8, number of response-bank slots (iids) tracked; power of two, at least 2.
REQ-002 SHALL have parameter DelayWidth, default 8, width of the per-entry delay in clock cycles.
REQ-003 SHALL have derived parameter IidWidth = $clog2(NumSlots) and CntWidth = $clog2(NumSlots+1).
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port entry_valid_i  input  1  new timed entry offered.
REQ-007 SHALL have port entry_ready_o  output  1  entry accepted this cycle if valid.
REQ-008 SHALL have port entry_iid_i  input  IidWidth  reserved bank slot (iid) the entry refers to.
REQ-009 SHALL have port entry_delay_i  input  DelayWidth  cycles to wait before release.
REQ-010 SHALL have port release_en_onehot_o  output  NumSlots  bit i high: slot i may be released by the response banks.
REQ-011 SHALL have port released_onehot_i  input  NumSlots  bit i high: response banks released slot i this cycle.
REQ-012 SHALL have port busy_cnt_o  output  CntWidth  number of non-FREE slots.

Function
REQ-013 SHALL hold per slot a 2-bit state (FREE, COUNTING, RELEASABLE) and a DelayWidth-bit down-counter.
REQ-014 SHALL drive entry_ready_o = (state[entry_iid_i] == FREE), combinationally; independent of entry_valid_i.
REQ-015 SHALL accept an entry (handshake) when entry_valid_i & entry_ready_o; no state change otherwise.
REQ-016 On handshake with delay D == 0, slot SHALL go FREE -> RELEASABLE at the next edge.
REQ-017 On handshake with D > 0, slot SHALL go FREE -> COUNTING with counter loaded to D.
REQ-018 In COUNTING, counter SHALL decrement by 1 each cycle; when counter == 1, slot SHALL go to RELEASABLE (counter to 0) at that edge.
REQ-019 Latency: handshake at cycle t SHALL produce release_en_onehot_o[iid] high from cycle t+1+D, for all D in 0..2^DelayWidth-1.
REQ-020 release_en_onehot_o[i] SHALL equal (state[i] == RELEASABLE), driven from registers only.
REQ-021 RELEASABLE SHALL persist indefinitely until released_onehot_i[i] is high, then go FREE at that edge.
REQ-022 released_onehot_i[i] while slot i is FREE or COUNTING SHALL be ignored (no state or counter change).
REQ-023 Multiple bits of released_onehot_i high in one cycle SHALL each be honoured independently.
REQ-024 A slot freed at edge e SHALL be acceptable (entry_ready_o high for that iid) in cycle e+1, not earlier; no same-cycle bypass.
REQ-025 Counters of different slots SHALL run concurrently and independently; one accept per cycle maximum.
REQ-026 Counters SHALL never wrap: decrement occurs only while COUNTING with counter >= 1.
REQ-027 busy_cnt_o SHALL be a register updated each edge: +1 on handshake, -1 per honoured release, net sum when both occur; range 0..NumSlots.

Reset
REQ-028 On rst_ni low, asynchronously: all slots FREE, all counters 0, busy_cnt_o = 0, release_en_onehot_o = 0.
REQ-029 Reset asserted mid-count SHALL discard all pending entries; after release, no release_en bit SHALL assert without a new handshake.
REQ-030 entry_ready_o SHALL read 1 for every iid while in reset and immediately after.

Verification
REQ-031 Accept iid 3, D=0 at cycle 10 -> release_en_onehot_o = 8'b0000_1000 at cycle 11; released_onehot_i[3] at cycle 13 -> bit clears at 14, busy_cnt_o 1 -> 0.
REQ-032 Accept iid 2 D=5 at cycle 0 and iid 5 D=1 at cycle 1 -> bit 5 high at cycle 3, bit 2 high at cycle 6; both released same cycle -> busy_cnt_o 2 -> 0 next edge.
REQ-033 Offer iid 2 again while COUNTING -> entry_ready_o = 0, counter and state unaffected; after release at edge e, re-accept succeeds in cycle e+1.
REQ-034 Accept iid 0 with D=255 -> release_en bit 0 first high exactly 256 cycles later; spurious released_onehot_i[0] at cycle 100 ignored.
REQ-035 Fill all 8 slots D=20, assert rst_ni low at cycle 12 for one cycle -> all outputs 0, busy_cnt_o 0, no release_en for next 40 cycles.
REQ-036 Same-cycle handshake on iid 1 and release of iid 4 -> busy_cnt_o unchanged.
